// File: rtl/gsim_pkg.sv
// ---------------------------------------------------------------------------
// gsim_pkg
// Shared constants for the GSIM solver and its output buffer: frame size,
// word widths, fixed-point shift and the output-buffer state encoding.
// Ports: none (package).
// ---------------------------------------------------------------------------
package gsim_pkg;

    // Words per solution frame; the solver uses the same N.
    localparam int GSIM_N     = 16;
    // Solver word width, signed Q16.16.
    localparam int GSIM_IN_W  = 32;
    // Output word width, signed Q8.8.
    localparam int GSIM_OUT_W = 16;
    // Q16.16 -> Q8.8 drops 8 fractional bits.
    localparam int GSIM_FRAC  = 8;

    // Output buffer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } gsim_state_t;

endpackage

// File: rtl/gsim_out_buf_if.sv
// ---------------------------------------------------------------------------
// gsim_out_buf_if
// Bundles the solver-side write strobe and the downstream valid/ready
// stream of the output buffer.
// Ports (signals):
//   x_valid, x_in          solver word strobe and Q16.16 data
//   o_ready                downstream accept
//   o_valid, o_data,       Q8.8 output word, its index, last-word flag
//   o_idx, o_last, o_sat   and saturation flag
// Modports: slave (the buffer), master (the environment driving it).
// ---------------------------------------------------------------------------
interface gsim_out_buf_if
    import gsim_pkg::*;
#(
    parameter int IN_W  = GSIM_IN_W,
    parameter int OUT_W = GSIM_OUT_W,
    parameter int IDX_W = $clog2(GSIM_N)
);
    logic             x_valid;
    logic [IN_W-1:0]  x_in;
    logic             o_ready;
    logic             o_valid;
    logic [OUT_W-1:0] o_data;
    logic [IDX_W-1:0] o_idx;
    logic             o_last;
    logic             o_sat;

    modport slave (
        input  x_valid, x_in, o_ready,
        output o_valid, o_data, o_idx, o_last, o_sat
    );

    modport master (
        output x_valid, x_in, o_ready,
        input  o_valid, o_data, o_idx, o_last, o_sat
    );
endinterface

// File: rtl/gsim_q_round.sv
// ---------------------------------------------------------------------------
// gsim_q_round
// Combinational Q16.16 -> Q8.8 conversion: round half up, then saturate.
// Ports:
//   x    in  IN_W   signed Q16.16 word
//   y    out OUT_W  rounded, saturated Q8.8 word
//   sat  out 1      y was clamped to the positive or negative limit
// ---------------------------------------------------------------------------
module gsim_q_round
    import gsim_pkg::*;
#(
    parameter int IN_W  = GSIM_IN_W,
    parameter int OUT_W = GSIM_OUT_W,
    parameter int FRAC  = GSIM_FRAC
)(
    input  logic [IN_W-1:0]  x,
    output logic [OUT_W-1:0] y,
    output logic             sat
);
    // One extra bit so adding the half-LSB can never wrap near full scale.
    localparam int SW = IN_W + 1;
    localparam logic signed [SW-1:0] HALF  = {{(SW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [SW-1:0] MAX_V = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_V = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shifted;

    // Arithmetic shift after adding half an output LSB gives round half up
    // for both signs; anything outside the output range is clamped.
    always_comb begin
        sum     = $signed({x[IN_W-1], x}) + HALF;
        shifted = sum >>> FRAC;
        y       = shifted[OUT_W-1:0];
        sat     = 1'b0;
        if (shifted > MAX_V) begin
            y   = {1'b0, {(OUT_W-1){1'b1}}};
            sat = 1'b1;
        end else if (shifted < MIN_V) begin
            y   = {1'b1, {(OUT_W-1){1'b0}}};
            sat = 1'b1;
        end
    end
endmodule

// File: rtl/gsim_out_buf.sv
// ---------------------------------------------------------------------------
// gsim_out_buf
// Captures one N-word Q16.16 solution frame from the solver, then streams it
// out as rounded/saturated Q8.8 words over a valid/ready handshake.
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-high
//   bus        if   gsim_out_buf_if.slave (x_valid/x_in, o_* stream)
//   busy       out  high while capturing or draining
//   frame_err  out  sticky: a solver word arrived while draining
// ---------------------------------------------------------------------------
module gsim_out_buf
    import gsim_pkg::*;
#(
    parameter int N     = GSIM_N,
    parameter int IN_W  = GSIM_IN_W,
    parameter int OUT_W = GSIM_OUT_W
)(
    input  logic          clk,
    input  logic          reset,
    gsim_out_buf_if.slave bus,
    output logic          busy,
    output logic          frame_err
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    gsim_state_t      state, state_next;
    logic [IN_W-1:0]  frame_buf [N];
    logic [CNT_W-1:0] wr_cnt;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_addr;
    logic             store_en, last_store, xfer, last_xfer, draining;
    logic [OUT_W-1:0] rnd_data;
    logic             rnd_sat;

    // Write/read qualifiers. A frame always starts at slot 0 from IDLE, and
    // solver words during DRAIN (including the last-transfer cycle) are never
    // stored, which keeps the drained data stable under backpressure.
    always_comb begin
        draining   = (state == DRAIN);
        wr_addr    = (state == CAPTURE) ? wr_cnt[IDX_W-1:0] : '0;
        store_en   = bus.x_valid && !draining && (wr_cnt < CNT_W'(N));
        last_store = store_en && (wr_addr == LAST_IDX);
        xfer       = draining && bus.o_ready;
        last_xfer  = xfer && (rd_idx == LAST_IDX);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (store_en)   state_next = last_store ? DRAIN : CAPTURE;
            CAPTURE: if (last_store) state_next = DRAIN;
            DRAIN:   if (last_xfer)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Write count, read index and the sticky overrun flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt    <= '0;
            rd_idx    <= '0;
            frame_err <= 1'b0;
        end else begin
            if (store_en) begin
                wr_cnt <= CNT_W'(wr_addr) + CNT_W'(1);
            end else if (last_xfer) begin
                wr_cnt <= '0;
            end
            if (last_store) begin
                rd_idx <= '0;
            end else if (xfer) begin
                rd_idx <= last_xfer ? '0 : rd_idx + IDX_W'(1);
            end
            if (bus.x_valid && draining) begin
                frame_err <= 1'b1;
            end
        end
    end

    // Frame storage: plain registers, contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (store_en) begin
            frame_buf[wr_addr] <= bus.x_in;
        end
    end

    gsim_q_round #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .FRAC (GSIM_FRAC)
    ) u_round (
        .x  (frame_buf[rd_idx]),
        .y  (rnd_data),
        .sat(rnd_sat)
    );

    // Output stream is a pure function of state and rd_idx, so it holds
    // steady while stalled and is forced to zero as soon as reset hits.
    always_comb begin
        bus.o_valid = draining;
        bus.o_data  = draining ? rnd_data : '0;
        bus.o_idx   = draining ? rd_idx : '0;
        bus.o_last  = draining && (rd_idx == LAST_IDX);
        bus.o_sat   = draining && rnd_sat;
        busy        = (state != IDLE);
    end
endmodule

// File: tb/tb_gsim_out_buf.sv
// ---------------------------------------------------------------------------
// tb_gsim_out_buf
// Directed, table-driven bench for gsim_out_buf.
// ---------------------------------------------------------------------------
module tb_gsim_out_buf;
    import gsim_pkg::*;

    localparam int N = 16;

    typedef struct {
        logic [31:0] x;
        logic [15:0] data;
        logic        sat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic frame_err;

    gsim_out_buf_if bus();

    gsim_out_buf dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    vec_t round_tbl [N];
    vec_t cur [N];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, return at the next one.
    task automatic applyStimulus(input logic xv, input logic [31:0] x, input logic rdy);
        bus.x_valid = xv;
        bus.x_in    = x;
        bus.o_ready = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic loadRamp();
        for (int k = 0; k < N; k++) begin
            cur[k].x    = k << 16;
            cur[k].data = 16'(k << 8);
            cur[k].sat  = 1'b0;
        end
    endtask

    task automatic loadNegRamp();
        for (int k = 0; k < N; k++) begin
            cur[k].x    = 32'(-(k << 16));
            cur[k].data = 16'(-(k << 8));
            cur[k].sat  = 1'b0;
        end
    endtask

    task automatic doReset();
        bus.x_valid = 1'b0;
        bus.x_in    = '0;
        bus.o_ready = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Write cur[] as one frame; o_ready is held high to show it is ignored
    // while nothing is valid. Optional idle cycle between words.
    task automatic sendFrame(input bit gap);
        for (int i = 0; i < N; i++) begin
            applyStimulus(1'b1, cur[i].x, 1'b1);
            if (i == 0) checkOutput("busy_capture", busy, 1);
            if (i == N - 2) checkOutput("valid_before_last", bus.o_valid, 0);
            if (gap && i < N - 1) applyStimulus(1'b0, 32'h0, 1'b1);
        end
        bus.x_valid = 1'b0;
        checkOutput("valid_latency", bus.o_valid, 1);
        checkOutput("first_idx", bus.o_idx, 0);
    endtask

    // Drain and compare against cur[]. stall=1 uses ready pattern 1,0,0,...
    // Solver words are injected on cycles [ov_start, ov_start+ov_count).
    task automatic receiveFrame(input bit stall, input int ov_start, input int ov_count);
        int          got = 0;
        int          cyc = 0;
        logic        rdy;
        logic        prev_stall = 1'b0;
        logic [15:0] prev_data = '0;
        logic [3:0]  prev_idx = '0;
        while (got < N && cyc < 200) begin
            rdy = stall ? (cyc % 3 == 0) : 1'b1;
            if (prev_stall) begin
                checkOutput("hold_valid", bus.o_valid, 1);
                checkOutput("hold_data", bus.o_data, prev_data);
                checkOutput("hold_idx", bus.o_idx, prev_idx);
            end
            if (bus.o_valid && rdy) begin
                checkOutput($sformatf("data[%0d]", got), bus.o_data, cur[got].data);
                checkOutput($sformatf("idx[%0d]", got), bus.o_idx, got);
                checkOutput($sformatf("last[%0d]", got), bus.o_last, (got == N - 1));
                checkOutput($sformatf("sat[%0d]", got), bus.o_sat, cur[got].sat);
                got++;
            end
            prev_stall = bus.o_valid && !rdy;
            prev_data  = bus.o_data;
            prev_idx   = bus.o_idx;
            applyStimulus((cyc >= ov_start) && (cyc < ov_start + ov_count),
                          32'h7ABC0000 + 32'(cyc), rdy);
            cyc++;
        end
        bus.x_valid = 1'b0;
        bus.o_ready = 1'b0;
        checkOutput("words_delivered", got, N);
        if (!stall) checkOutput("drain_cycles", cyc, N);
        checkOutput("valid_drop", bus.o_valid, 0);
    endtask

    initial begin
        round_tbl[0]  = '{32'h00018080, 16'h0181, 1'b0};
        round_tbl[1]  = '{32'h0001807F, 16'h0180, 1'b0};
        round_tbl[2]  = '{32'hFFFFFF80, 16'h0000, 1'b0};
        round_tbl[3]  = '{32'hFFFFFF7F, 16'hFFFF, 1'b0};
        round_tbl[4]  = '{32'h7FFFFFFF, 16'h7FFF, 1'b1};
        round_tbl[5]  = '{32'h80000000, 16'h8000, 1'b1};
        round_tbl[6]  = '{32'h007FFF7F, 16'h7FFF, 1'b0};
        round_tbl[7]  = '{32'h00800000, 16'h7FFF, 1'b1};
        round_tbl[8]  = '{32'hFF7FFF80, 16'h8000, 1'b0};
        round_tbl[9]  = '{32'hFF7FFF7F, 16'h8000, 1'b1};
        round_tbl[10] = '{32'h00000000, 16'h0000, 1'b0};
        round_tbl[11] = '{32'h00010000, 16'h0100, 1'b0};
        round_tbl[12] = '{32'hFFFF0000, 16'hFF00, 1'b0};
        round_tbl[13] = '{32'h00000080, 16'h0001, 1'b0};
        round_tbl[14] = '{32'h0000007F, 16'h0000, 1'b0};
        round_tbl[15] = '{32'h12345678, 16'h7FFF, 1'b1};

        bus.x_valid = 1'b0;
        bus.x_in    = '0;
        bus.o_ready = 1'b0;
        reset       = 1'b1;
        #2;
        checkOutput("rst_o_valid", bus.o_valid, 0);
        checkOutput("rst_o_data", bus.o_data, 0);
        checkOutput("rst_o_idx", bus.o_idx, 0);
        checkOutput("rst_o_last", bus.o_last, 0);
        checkOutput("rst_o_sat", bus.o_sat, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_frame_err", frame_err, 0);
        doReset();

        $display("[TB] ramp frame, ready held high");
        loadRamp();
        sendFrame(1'b0);
        receiveFrame(1'b0, 0, 0);
        checkOutput("ramp_busy_after", busy, 0);
        checkOutput("ramp_frame_err", frame_err, 0);

        $display("[TB] rounding/saturation table, gapped writes");
        foreach (cur[i]) cur[i] = round_tbl[i];
        sendFrame(1'b1);
        receiveFrame(1'b0, 0, 0);

        $display("[TB] backpressure 1,0,0 pattern");
        loadRamp();
        sendFrame(1'b0);
        receiveFrame(1'b1, 0, 0);
        checkOutput("bp_frame_err", frame_err, 0);

        $display("[TB] overrun during drain");
        loadRamp();
        sendFrame(1'b0);
        receiveFrame(1'b0, 2, 3);
        checkOutput("ovr_frame_err", frame_err, 1);
        checkOutput("ovr_busy_after", busy, 0);
        loadNegRamp();
        sendFrame(1'b0);
        receiveFrame(1'b0, 0, 0);
        checkOutput("ovr_err_sticky", frame_err, 1);

        $display("[TB] solver word on last-transfer cycle");
        doReset();
        checkOutput("reset_clears_err", frame_err, 0);
        loadRamp();
        sendFrame(1'b0);
        receiveFrame(1'b0, N - 1, 1);
        checkOutput("lastxfer_frame_err", frame_err, 1);
        checkOutput("lastxfer_busy", busy, 0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("lastxfer_still_idle", busy, 0);
        checkOutput("lastxfer_no_valid", bus.o_valid, 0);

        $display("[TB] reset in the middle of capture");
        doReset();
        loadRamp();
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, cur[i].x, 1'b0);
        checkOutput("midcap_busy", busy, 1);
        bus.x_valid = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("midcap_async_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        loadNegRamp();
        sendFrame(1'b0);
        receiveFrame(1'b0, 0, 0);
        checkOutput("midcap_frame_err", frame_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/gsim_out_buf.md
GSIM_OUT_BUF -- requirements
Module: gsim_out_buf

Interface
REQ-001 Parameter N, default 16: words per solution frame.
REQ-002 Parameter IN_W, default 32: input word width, signed Q16.16.
REQ-003 Parameter OUT_W, default 16: output word width, signed Q8.8.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 x_valid  input  1: solver output strobe; one x word per cycle when high.
REQ-007 x_in  input  IN_W: solver x word, signed Q16.16, order x0..x(N-1).
REQ-008 o_ready  input  1: downstream accepts o_data this cycle.
REQ-009 o_valid  output  1: o_data/o_idx/o_last/o_sat are valid.
REQ-010 o_data  output  OUT_W: rounded, saturated Q8.8 word.
REQ-011 o_idx  output  $clog2(N): index of the word on o_data.
REQ-012 o_last  output  1: high with o_valid when o_idx == N-1.
REQ-013 o_sat  output  1: the word on o_data was saturated.
REQ-014 busy  output  1: high in CAPTURE or DRAIN.
REQ-015 frame_err  output  1: sticky overrun flag.

Function
REQ-016 The FSM SHALL have states IDLE, CAPTURE and DRAIN.
REQ-017 In IDLE, x_valid SHALL store x_in at buf[0], set wr_cnt=1 and move to CAPTURE.
REQ-018 In CAPTURE, each x_valid SHALL store x_in at buf[wr_cnt] and increment wr_cnt. Gaps in x_valid are allowed and hold state.
REQ-019 The store of word N-1 SHALL move the FSM to DRAIN, with rd_idx=0.
REQ-020 o_valid SHALL rise in the cycle after the word N-1 store (1-cycle latency).
REQ-021 Conversion SHALL be computed in IN_W+1 bits with no intermediate wrap: y = (x + 0x80) >>> 8 (arithmetic shift, round half up).
REQ-022 If y > 32767, o_data SHALL be 0x7FFF; if y < -32768, o_data SHALL be 0x8000; o_sat SHALL be 1 in both cases.
REQ-023 In DRAIN, o_valid SHALL stay high and o_data/o_idx/o_last/o_sat SHALL stay stable until o_valid && o_ready.
REQ-024 On each transfer, rd_idx SHALL increment. On the transfer with o_last high, the FSM SHALL return to IDLE and o_valid SHALL drop the next cycle.
REQ-025 Throughput in DRAIN SHALL be one word per cycle while o_ready is held high.
REQ-026 An x_valid during DRAIN SHALL be dropped and SHALL set frame_err to 1 until reset.
REQ-027 On the cycle of the last transfer, an x_valid SHALL be treated as an overrun and dropped, not as the start of a new frame.
REQ-028 o_ready while o_valid is low SHALL have no effect.
REQ-029 Counters SHALL not wrap: wr_cnt ≤ N and rd_idx ≤ N-1.

Reset
REQ-030 Asserting reset SHALL immediately force IDLE, wr_cnt=0, rd_idx=0, o_valid=0, o_data=0, o_idx=0, o_last=0, o_sat=0, busy=0, frame_err=0.
REQ-031 Buffer contents need not be cleared by reset.
REQ-032 Reset mid-CAPTURE or mid-DRAIN SHALL discard the partial frame. The first x_valid after reset release starts a new frame at buf[0].

Structure
REQ-033 N, IN_W, OUT_W, FRAC shift (8) and the state encoding SHALL live in a shared package gsim_pkg, which the solver's N also uses.
REQ-034 Round and saturate logic SHALL be one combinational sub-module, gsim_q_round (IN_W in; OUT_W out plus sat flag), placed on the read path.
REQ-035 The buffer SHALL be an N x IN_W register array with no RAM macro.

Verification
REQ-036 16 contiguous x_valid words, x_k = k<<16 (k=0..15), o_ready=1 -> o_data = k<<8 (0x0000..0x0F00) on 16 consecutive cycles starting 1 cycle after word 15, o_last only on idx 15, o_sat=0.
REQ-037 Rounding: x=0x00018080 -> 0x0181; x=0x0001807F -> 0x0180; x=0xFFFFFF80 -> 0x0000; x=0xFFFFFF7F -> 0xFFFF.
REQ-038 Saturation: x=0x7FFFFFFF -> 0x7FFF, o_sat=1; x=0x80000000 -> 0x8000, o_sat=1; x=0x007FFF7F -> 0x7FFF, o_sat=0.
REQ-039 Backpressure: o_ready toggles 1,0,0,1,... -> o_data held stable while stalled, all 16 words delivered in order with none lost or duplicated.
REQ-040 Overrun: 3 x_valid words during DRAIN -> frame_err=1, drained words are from the first frame only, and frame_err stays 1 through the next frame.
REQ-041 Reset at word 7 of CAPTURE, then a full new frame -> output is exactly the new frame's 16 words and frame_err=0.
